// File: rtl/result_packer_if.sv
// Stream interface of the result packer: an upstream beat carrying operands and the raw
// computed result, and the packed downstream beat.
interface result_packer_if #(
   parameter int unsigned EXP_WIDTH  = 8,
   parameter int unsigned FRAC_WIDTH = 23
);
   localparam int unsigned W = 1 + EXP_WIDTH + FRAC_WIDTH;

   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            mode;
   logic                  check_result;
   logic [W-1:0]          operand_a;
   logic [W-1:0]          operand_b;
   logic                  result_sign;
   logic [EXP_WIDTH+1:0]  result_exponent;
   logic [FRAC_WIDTH+8:0] result_fraction;
   logic                  out_valid;
   logic                  out_ready;
   logic [W-1:0]          result;
   logic [2:0]            flags;

   modport master (
      output in_valid, mode, check_result, operand_a, operand_b, result_sign,
             result_exponent, result_fraction, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, mode, check_result, operand_a, operand_b, result_sign,
             result_exponent, result_fraction, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/result_packer.sv
// Two-stage result packer: S1 normalises and rounds to nearest even, S2 range-checks,
// handles the special modes and packs sign/exponent/fraction with {overflow, underflow, inexact}.
module result_packer #(
   parameter int unsigned EXP_WIDTH  = 8,
   parameter int unsigned FRAC_WIDTH = 23
) (
   input logic            clk,
   input logic            reset,
   result_packer_if.slave bus
);
   localparam int unsigned W  = 1 + EXP_WIDTH + FRAC_WIDTH;
   localparam int unsigned SW = FRAC_WIDTH + 1;
   // One extra bit over the input exponent so the normalise and round increments cannot wrap.
   localparam int unsigned XW = EXP_WIDTH + 3;

   localparam logic signed [XW-1:0] ExpMax  = XW'((1 << EXP_WIDTH) - 1);
   localparam logic signed [XW-1:0] ExpZero = '0;

   localparam logic [2:0] ModeCalc  = 3'd0;
   localparam logic [2:0] ModePassA = 3'd1;
   localparam logic [2:0] ModePassB = 3'd2;
   localparam logic [2:0] ModeQnan  = 3'd3;
   localparam logic [2:0] ModeInf   = 3'd4;
   localparam logic [2:0] ModeZero  = 3'd5;

   // Handshake
   logic s1_full_q, s2_full_q;
   logic s1_advance, in_ready, accept;

   assign s1_advance    = !s2_full_q || bus.out_ready;
   assign in_ready      = !s1_full_q || s1_advance;
   assign accept        = bus.in_valid && in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_full_q;

   // S1: normalise and round
   logic [FRAC_WIDTH+8:0] frac_in;
   logic signed [XW-1:0]  exp_in, exp_norm, exp_rnd;
   logic [SW-1:0]         sig_norm;
   logic [FRAC_WIDTH-1:0] frac_rnd;
   logic                  guard, sticky, round_up;
   logic [2:0]            mode_in;
   logic [W-1:0]          opnd_in;

   always_comb begin
      frac_in = bus.result_fraction;
      exp_in  = {bus.result_exponent[EXP_WIDTH+1], bus.result_exponent};
      if (frac_in[FRAC_WIDTH+8]) begin
         sig_norm = frac_in[FRAC_WIDTH+8:8];
         guard    = frac_in[7];
         sticky   = |frac_in[6:0];
         exp_norm = exp_in + XW'(1);
      end else begin
         sig_norm = frac_in[FRAC_WIDTH+7:7];
         guard    = frac_in[6];
         sticky   = |frac_in[5:0];
         exp_norm = exp_in;
      end
      round_up = guard && (sticky || sig_norm[0]);
      // The stored fraction wraps to zero on carry-out, which is exactly 1.000..0.
      frac_rnd = sig_norm[FRAC_WIDTH-1:0] + FRAC_WIDTH'(round_up);
      exp_rnd  = (round_up && (&sig_norm)) ? exp_norm + XW'(1) : exp_norm;
      mode_in  = (bus.mode > ModeZero) ? ModeQnan : bus.mode;
      opnd_in  = (bus.mode == ModePassB) ? bus.operand_b : bus.operand_a;
   end

   logic [2:0]            s1_mode_q;
   logic                  s1_check_q, s1_sign_q, s1_inexact_q;
   logic signed [XW-1:0]  s1_exp_q;
   logic [FRAC_WIDTH-1:0] s1_frac_q;
   logic [W-1:0]          s1_opnd_q;

   // S2: range check and pack
   logic [W-1:0] result_d, result_q;
   logic [2:0]   flags_d, flags_q;

   always_comb begin
      result_d = '0;
      flags_d  = '0;
      case (s1_mode_q)
         ModeCalc: begin
            result_d = {s1_sign_q, s1_exp_q[EXP_WIDTH-1:0], s1_frac_q};
            flags_d  = {2'b00, s1_inexact_q};
            if (s1_check_q && (s1_exp_q >= ExpMax)) begin
               result_d = {s1_sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
               flags_d  = 3'b101;
            end else if (s1_check_q && (s1_exp_q <= ExpZero)) begin
               result_d = {s1_sign_q, {(W-1){1'b0}}};
               flags_d  = 3'b011;
            end
         end
         ModePassA, ModePassB: begin
            result_d = s1_opnd_q;
            if ((&s1_opnd_q[W-2:FRAC_WIDTH]) && (|s1_opnd_q[FRAC_WIDTH-1:0])) begin
               result_d[FRAC_WIDTH-1] = 1'b1;
            end
         end
         ModeInf:  result_d = {s1_sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
         ModeZero: result_d = {s1_sign_q, {(W-1){1'b0}}};
         default:  result_d = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
      endcase
   end

   assign bus.result = result_q;
   assign bus.flags  = flags_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_full_q    <= 1'b0;
         s2_full_q    <= 1'b0;
         s1_mode_q    <= ModeCalc;
         s1_check_q   <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_inexact_q <= 1'b0;
         s1_exp_q     <= '0;
         s1_frac_q    <= '0;
         s1_opnd_q    <= '0;
         result_q     <= '0;
         flags_q      <= '0;
      end else begin
         if (in_ready) begin
            s1_full_q <= bus.in_valid;
         end
         if (accept) begin
            s1_mode_q    <= mode_in;
            s1_check_q   <= bus.check_result;
            s1_sign_q    <= bus.result_sign;
            s1_inexact_q <= guard || sticky;
            s1_exp_q     <= exp_rnd;
            s1_frac_q    <= frac_rnd;
            s1_opnd_q    <= opnd_in;
         end
         if (s1_advance) begin
            s2_full_q <= s1_full_q;
            // An empty S1 leaves the last result and flags on the outputs.
            if (s1_full_q) begin
               result_q <= result_d;
               flags_q  <= flags_d;
            end
         end
      end
   end
endmodule

// File: doc/result_packer.md
RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 Parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 Parameter FRAC_WIDTH, default 23, stored fraction width; W = 1+EXP_WIDTH+FRAC_WIDTH.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  input beat valid.
REQ-006 Port in_ready  output  1  block accepts beat this cycle.
REQ-007 Port mode  input  3  0 computed, 1 pass operand A, 2 pass operand B, 3 quiet NaN, 4 infinity, 5 zero; 6-7 treated as 3.
REQ-008 Port check_result  input  1  enable overflow/underflow checks in mode 0.
REQ-009 Port operand_a, operand_b  input  W each  packed IEEE-style operands.
REQ-010 Port result_sign  input  1  computed sign; also sign for modes 4-5.
REQ-011 Port result_exponent  input  EXP_WIDTH+2  biased exponent, two's complement.
REQ-012 Port result_fraction  input  FRAC_WIDTH+9  format xx.f, 2 integer bits, FRAC_WIDTH+7 fraction bits.
REQ-013 Port out_valid  output  1  result beat valid.
REQ-014 Port out_ready  input  1  downstream accepts beat.
REQ-015 Port result  output  W  packed result.
REQ-016 Port flags  output  3  {overflow, underflow, inexact}.

Function
REQ-017 Two-stage pipeline: S1 normalise+round, S2 range check+pack; latency exactly 2 cycles with out_ready held high.
REQ-018 Beat transfers in when in_valid&&in_ready, out when out_valid&&out_ready.
REQ-019 in_ready = !S1_full || (S1 advances this cycle); S1 advances when !S2_full || out_ready; no combinational path in_valid->in_ready.
REQ-020 While out_valid && !out_ready, result, flags, out_valid stay stable; full throughput (1 beat/cycle) when out_ready constantly high.
REQ-021 S1 normalise: if result_fraction[FRAC_WIDTH+8]=1, significand=bits[FRAC_WIDTH+8:8], guard=bit7, sticky=OR bits[6:0], exponent+1; else significand=bits[FRAC_WIDTH+7:7], guard=bit6, sticky=OR bits[5:0].
REQ-022 S1 round to nearest even: increment significand when guard && (sticky || significand LSB); carry-out sets significand to 1.000..0 and exponent+1.
REQ-023 inexact = guard||sticky, mode 0 only; 0 in all other modes.
REQ-024 S2 mode 0, check_result=1: exponent >= 2^EXP_WIDTH-1 -> signed infinity, overflow=1, inexact=1; exponent <= 0 -> signed zero, underflow=1, inexact=1 (no subnormals).
REQ-025 S2 mode 0, check_result=0: pack exponent low EXP_WIDTH bits and significand low FRAC_WIDTH bits unchecked; overflow=underflow=0.
REQ-026 Mode 1/2: result = operand_a/operand_b with fraction MSB forced 1 if operand is NaN (exp all ones, fraction nonzero); flags 0.
REQ-027 Mode 3: result = 0, exp all ones, fraction MSB 1, rest 0; mode 4: result_sign, exp all ones, fraction 0; mode 5: result_sign, all else 0.
REQ-028 Unused pipeline stage contents do not affect outputs; out_valid=0 implies flags and result are don't-care but held at last value.

Reset
REQ-029 reset=1 clears S1_full, S2_full; next cycle out_valid=0, in_ready=1, result=0, flags=0.
REQ-030 reset mid-operation discards all in-flight beats; beats presented during reset are not accepted.

Verification
REQ-031 E=8,F=23, mode 0, exp=127, fraction=01.0...0 -> result 0x3F800000, flags 000, out_valid 2 cycles later.
REQ-032 mode 0, check=1, exp=254, fraction=1x.xx (top set) -> 0x7F800000, flags 101.
REQ-033 exp=127, fraction 01.0..0 with guard=1, sticky=0, LSB=0 -> 0x3F800000 inexact=1; LSB=1 -> 0x3F800002.
REQ-034 Stream 4 beats, out_ready low 3 cycles after first out_valid -> result stable, in_ready low after both stages full, no beat lost or duplicated.
REQ-035 mode 2, operand_b=0x7F800001 -> 0x7FC00001; mode 3 -> 0x7FC00000.
REQ-036 Assert reset with two beats in flight -> out_valid=0 next cycle, no stale beat emitted after release.
